// File: rtl/cmp_pipe_if.sv
// Handshake bundle for cmp_pipe.
//   in_valid/in_ready : operand-pair handshake (a, b, ext)
//   out_valid/out_ready : result handshake (lt, eq, gt, diff)
// master = producer/consumer side (the environment), slave = the compare pipe.
interface cmp_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        ext;
    logic        out_valid;
    logic        out_ready;
    logic        lt;
    logic        eq;
    logic        gt;
    logic [63:0] diff;

    modport master (
        output in_valid, a, b, ext, out_ready,
        input  in_ready, out_valid, lt, eq, gt, diff
    );

    modport slave (
        input  in_valid, a, b, ext, out_ready,
        output in_ready, out_valid, lt, eq, gt, diff
    );
endinterface

// File: rtl/cmp_pipe.sv
// Two-stage 64-bit compare/subtract pipe.
// Operands are extended to 65 bits (sign-extend when ext=0, zero-extend when
// ext=1) and compared as two's-complement values; diff is a-b mod 2^64.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   io    : cmp_pipe_if.slave (input handshake + operands, output handshake + flags/diff)
// S1 does the low 32-bit subtraction and captures the extended high halves;
// S2 finishes the high subtraction and registers flags/diff, which drive the
// outputs directly.
module cmp_pipe (
    input logic       clk,
    input logic       reset,
    cmp_pipe_if.slave io
);
    logic        s1_valid, s2_valid;
    logic        s1_en, s2_en;

    logic [31:0] s1_dlo;
    logic        s1_borrow;
    logic        s1_zlo;
    logic [32:0] s1_ahi, s1_bhi;

    logic [32:0] lo_sub;
    logic [32:0] a_hi, b_hi;
    logic [33:0] hi_sub;
    logic        hi_zero;

    logic        lt_r, eq_r, gt_r;
    logic [63:0] diff_r;

    assign s2_en       = ~s2_valid | io.out_ready;
    assign s1_en       = ~s1_valid | s2_en;
    // Stages read as empty while reset is held, before the first edge clears them.
    assign io.in_ready = s1_en | reset;

    assign lo_sub = {1'b0, io.a[31:0]} - {1'b0, io.b[31:0]};
    assign a_hi   = {~io.ext & io.a[63], io.a[63:32]};
    assign b_hi   = {~io.ext & io.b[63], io.b[63:32]};

    // A-B = hi_sub*2^32 + dlo with 0 <= dlo < 2^32, so the sign of the full
    // difference is the sign of hi_sub, and zero needs both halves zero.
    assign hi_sub  = {s1_ahi[32], s1_ahi} - {s1_bhi[32], s1_bhi} - {33'd0, s1_borrow};
    assign hi_zero = (hi_sub == 34'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_dlo    <= '0;
            s1_borrow <= 1'b0;
            s1_zlo    <= 1'b0;
            s1_ahi    <= '0;
            s1_bhi    <= '0;
        end else if (s1_en) begin
            s1_valid  <= io.in_valid;
            s1_dlo    <= lo_sub[31:0];
            s1_borrow <= lo_sub[32];
            s1_zlo    <= (lo_sub[31:0] == 32'd0);
            s1_ahi    <= a_hi;
            s1_bhi    <= b_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            lt_r     <= 1'b0;
            eq_r     <= 1'b0;
            gt_r     <= 1'b0;
            diff_r   <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            diff_r   <= {hi_sub[31:0], s1_dlo};
            lt_r     <= hi_sub[33];
            eq_r     <= hi_zero & s1_zlo;
            gt_r     <= ~hi_sub[33] & ~(hi_zero & s1_zlo);
        end
    end

    assign io.out_valid = s2_valid;
    assign io.lt        = lt_r;
    assign io.eq        = eq_r;
    assign io.gt        = gt_r;
    assign io.diff      = diff_r;
endmodule

// File: tb/tb_cmp_pipe.sv
module tb_cmp_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cmp_pipe_if io();
    cmp_pipe dut (.clk(clk), .reset(reset), .io(io));

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        ext;
        logic        lt, eq, gt;
        logic [63:0] diff;
    } vec_t;

    typedef struct {
        logic [66:0] r;
        int          t;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cycle = 0;
    int          ndeliv = 0;
    exp_t        q[$];
    logic        prev_stall = 1'b0;
    logic [66:0] prev_out = '0;
    vec_t        tv[8];

    task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: 65-bit two's-complement compare plus 64-bit wraparound subtract.
    function automatic logic [66:0] refm(input logic [63:0] av, input logic [63:0] bv, input logic ev);
        logic signed [64:0] ea, eb;
        ea = {~ev & av[63], av};
        eb = {~ev & bv[63], bv};
        return {ea < eb, ea == eb, ea > eb, av - bv};
    endfunction

    task automatic rnd_pair(output logic [63:0] av, output logic [63:0] bv);
        int sel;
        av  = {$urandom, $urandom};
        sel = $urandom_range(0, 3);
        if (sel == 0)      bv = av;
        else if (sel == 1) bv = av ^ (64'd1 << $urandom_range(0, 63));
        else               bv = {$urandom, $urandom};
    endtask

    // One clock of stimulus; checks handshake and data against the model.
    task automatic cyc(input logic iv, input logic [63:0] av, input logic [63:0] bv,
                       input logic ev, input logic ordy, output logic acc);
        logic exp_rdy, exp_ov;
        exp_t e;
        @(negedge clk);
        io.in_valid  = iv;
        io.a         = av;
        io.b         = bv;
        io.ext       = ev;
        io.out_ready = ordy;
        #1;
        exp_rdy = (q.size() < 2) || ordy;
        exp_ov  = (q.size() > 0) && (cycle - q[0].t >= 2);
        chk("in_ready", io.in_ready, exp_rdy);
        chk("out_valid", io.out_valid, exp_ov);
        if (exp_ov && prev_stall)
            chk("stall_hold", {io.lt, io.eq, io.gt, io.diff}, prev_out);
        if (exp_ov && ordy) begin
            e = q.pop_front();
            chk("result", {io.lt, io.eq, io.gt, io.diff}, e.r);
            ndeliv++;
        end
        acc = iv && exp_rdy;
        if (acc) q.push_back('{r: refm(av, bv, ev), t: cycle});
        prev_stall = exp_ov && !ordy;
        prev_out   = {io.lt, io.eq, io.gt, io.diff};
        cycle++;
    endtask

    // Reset with a pair offered and the consumer stalled; the pair must vanish.
    task automatic do_reset(input int ncyc);
        @(negedge clk);
        reset        = 1'b1;
        io.in_valid  = 1'b1;
        io.a         = {$urandom, $urandom};
        io.b         = {$urandom, $urandom};
        io.ext       = 1'b0;
        io.out_ready = 1'b0;
        #1;
        chk("rst_in_ready", io.in_ready, 1'b1);
        repeat (ncyc - 1) @(negedge clk);
        @(negedge clk);
        reset        = 1'b0;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", io.out_valid, 1'b0);
        chk("rst_outputs", {io.lt, io.eq, io.gt, io.diff}, 67'd0);
        chk("rst_in_ready_after", io.in_ready, 1'b1);
        q.delete();
        prev_stall = 1'b0;
        cycle++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc, saw_drop;
        logic [63:0] ra, rb;
        logic [63:0] bpa[4], bpb[4];
        int          p, used, d0;

        tv[0] = '{64'h8000_0000_0000_0000, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000};
        tv[1] = '{64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000};
        tv[2] = '{64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0};
        tv[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        tv[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
        tv[5] = '{64'h1_0000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1};
        tv[6] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0};
        tv[7] = '{64'h5, 64'h7, 1'b0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};

        io.in_valid  = 1'b0;
        io.a         = '0;
        io.b         = '0;
        io.ext       = 1'b0;
        io.out_ready = 1'b1;
        do_reset(2);

        // Directed vectors: one pair at a time, latency exactly 2.
        foreach (tv[i]) begin
            @(negedge clk);
            io.in_valid  = 1'b1;
            io.a         = tv[i].a;
            io.b         = tv[i].b;
            io.ext       = tv[i].ext;
            io.out_ready = 1'b1;
            #1;
            chk("tv_in_ready", io.in_ready, 1'b1);
            @(negedge clk);
            io.in_valid = 1'b0;
            #1;
            chk("tv_out_valid_c1", io.out_valid, 1'b0);
            @(negedge clk);
            #1;
            chk("tv_out_valid_c2", io.out_valid, 1'b1);
            chk("tv_flags", {io.lt, io.eq, io.gt}, {tv[i].lt, tv[i].eq, tv[i].gt});
            chk("tv_diff", io.diff, tv[i].diff);
        end
        prev_stall = 1'b0;

        // Backpressure: 4 pairs, out_ready low on cycles 2..5.
        for (int k = 0; k < 4; k++) rnd_pair(bpa[k], bpb[k]);
        p = 0;
        saw_drop = 1'b0;
        d0 = ndeliv;
        for (int k = 0; k < 14; k++) begin
            if (p < 4) cyc(1'b1, bpa[p], bpb[p], p[0], !(k >= 2 && k <= 5), acc);
            else       cyc(1'b0, 64'h0, 64'h0, 1'b0, !(k >= 2 && k <= 5), acc);
            if (!io.in_ready) saw_drop = 1'b1;
            if (acc) p++;
        end
        chk("bp_in_ready_dropped", saw_drop, 1'b1);
        chk("bp_delivered", ndeliv - d0, 4);

        // Throughput: 100 back-to-back pairs with the consumer always ready.
        p = 0;
        used = 0;
        d0 = ndeliv;
        while (p < 100 && used < 150) begin
            rnd_pair(ra, rb);
            cyc(1'b1, ra, rb, $urandom_range(0, 1), 1'b1, acc);
            used++;
            if (acc) p++;
        end
        repeat (3) cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, acc);
        chk("tput_cycles", used, 100);
        chk("tput_delivered", ndeliv - d0, 100);

        // Random handshakes on both sides.
        for (int k = 0; k < 300; k++) begin
            rnd_pair(ra, rb);
            cyc($urandom_range(0, 1), ra, rb, $urandom_range(0, 1), $urandom_range(0, 3) != 0, acc);
        end
        repeat (4) cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, acc);

        // Reset with both stages full; no stale result may surface.
        for (int k = 0; k < 3; k++) begin
            rnd_pair(ra, rb);
            cyc(1'b1, ra, rb, 1'b0, 1'b0, acc);
        end
        do_reset(1);
        repeat (4) cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, acc);
        d0 = ndeliv;
        cyc(1'b1, 64'h1_0000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, acc);
        repeat (4) cyc(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, acc);
        chk("post_rst_delivered", ndeliv - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
